// File: rtl/wash_sequencer.sv
// wash_sequencer: washing-machine program sequencer (fill/agitate/drain/spin) with pause and time accounting
// Ports: clk, reset (async active-low); tick (1 per machine second), start, pause (toggle), weight, mode (one-hot program)
//        running/paused/done, fill_valve/drain_valve/motor, stage, rinse_idx, water_level, elapsed_time, total_time
module wash_sequencer #(
    parameter int TIME_W   = 8,
    parameter int WEIGHT_W = 3,
    parameter int RINSE_N  = 2,
    parameter int FILL_K   = 2,
    parameter int WASH_K   = 2,
    parameter int RINSE_K  = 1,
    parameter int SPIN_K   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                start,
    input  logic                pause,
    input  logic [WEIGHT_W-1:0] weight,
    input  logic [5:0]          mode,
    output logic                running,
    output logic                paused,
    output logic                done,
    output logic                fill_valve,
    output logic                drain_valve,
    output logic                motor,
    output logic [1:0]          stage,
    output logic [2:0]          rinse_idx,
    output logic [7:0]          water_level,
    output logic [TIME_W-1:0]   elapsed_time,
    output logic [TIME_W-1:0]   total_time
);
    localparam logic [2:0] IDLE = 3'd0, FILL = 3'd1, AGITATE = 3'd2, DRAIN = 3'd3, SPIN = 3'd4, DONE = 3'd5;
    localparam logic [15:0] TMAX = 16'((1 << TIME_W) - 1);
    localparam logic [TIME_W-1:0] ONE = 1;

    function automatic logic [7:0] fill_tgt(input logic [WEIGHT_W-1:0] x);
        logic [15:0] p;
        p = 16'(FILL_K) * 16'(x);
        return (p > 16'd255) ? 8'hff : p[7:0];
    endfunction

    logic [2:0] state, state_n;
    logic [1:0] stage_n;
    logic [2:0] ridx_n;
    logic [7:0] water_n, tgt;
    logic [15:0] cnt, cnt_n, cnt_inc, w_in, w_lt, tgt_in, tot16, agit_len, spin_len;
    logic [TIME_W-1:0] el_n, tot_n;
    logic [WEIGHT_W-1:0] wl, wl_n;
    logic hr, hs, hr_n, hs_n, pz_n, hw_i, hr_i, hs_i, ok, act_n;

    assign hw_i = mode[5] | mode[4] | mode[3];
    assign hr_i = mode[5] | mode[3] | mode[2] | mode[1];
    assign hs_i = mode[5] | mode[1] | mode[0];
    assign ok = (weight != '0) && (mode != 6'd0) && ((mode & (mode - 6'd1)) == 6'd0);
    assign w_in = 16'(weight);
    assign w_lt = 16'(wl);
    assign tgt_in = {8'd0, fill_tgt(weight)};
    assign tgt = fill_tgt(wl);
    // Each fill/drain pair costs twice the fill target in ticks
    assign tot16 = (hw_i ? 16'd2 * tgt_in + 16'(WASH_K) * w_in : 16'd0)
                 + (hr_i ? 16'(RINSE_N) * (16'd2 * tgt_in + 16'(RINSE_K) * w_in) : 16'd0)
                 + (hs_i ? 16'(SPIN_K) * w_in : 16'd0);
    assign agit_len = (stage == 2'd1) ? 16'(WASH_K) * w_lt : 16'(RINSE_K) * w_lt;
    assign spin_len = 16'(SPIN_K) * w_lt;
    assign cnt_inc = cnt + 16'd1;

    always_comb begin
        state_n = state;
        stage_n = stage;
        ridx_n  = rinse_idx;
        water_n = water_level;
        cnt_n   = cnt;
        el_n    = elapsed_time;
        tot_n   = total_time;
        wl_n    = wl;
        hr_n    = hr;
        hs_n    = hs;
        pz_n    = paused;
        if (state == IDLE || state == DONE) begin
            if (start && ok) begin
                wl_n    = weight;
                hr_n    = hr_i;
                hs_n    = hs_i;
                el_n    = '0;
                tot_n   = (tot16 > TMAX) ? '1 : tot16[TIME_W-1:0];
                water_n = 8'd0;
                cnt_n   = 16'd0;
                state_n = (hw_i || hr_i) ? FILL : SPIN;
                stage_n = hw_i ? 2'd1 : hr_i ? 2'd2 : 2'd3;
                ridx_n  = (!hw_i && hr_i) ? 3'd1 : 3'd0;
            end
        end else if (pause) begin
            // pause wins over a coincident tick, which is simply dropped
            pz_n = !paused;
        end else if (tick && !paused) begin
            el_n = (elapsed_time == '1) ? elapsed_time : elapsed_time + ONE;
            case (state)
                FILL: begin
                    water_n = water_level + 8'd1;
                    if (water_n >= tgt) begin
                        state_n = AGITATE;
                        cnt_n   = 16'd0;
                    end
                end
                AGITATE: begin
                    cnt_n = cnt_inc;
                    if (cnt_inc >= agit_len) begin
                        state_n = DRAIN;
                        cnt_n   = 16'd0;
                    end
                end
                DRAIN: begin
                    water_n = water_level - 8'd1;
                    if (water_n == 8'd0) begin
                        if ((stage == 2'd1 && hr) || (stage == 2'd2 && rinse_idx < 3'(RINSE_N))) begin
                            state_n = FILL;
                            stage_n = 2'd2;
                            ridx_n  = rinse_idx + 3'd1;
                        end else begin
                            state_n = hs ? SPIN : DONE;
                            stage_n = hs ? 2'd3 : 2'd0;
                            ridx_n  = 3'd0;
                        end
                    end
                end
                SPIN: begin
                    cnt_n = cnt_inc;
                    if (cnt_inc >= spin_len) begin
                        state_n = DONE;
                        stage_n = 2'd0;
                        cnt_n   = 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign act_n = (state_n == FILL) || (state_n == AGITATE) || (state_n == DRAIN) || (state_n == SPIN);

    // Control outputs are registered from the next state so they track the FSM without input-to-output paths
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            stage        <= 2'd0;
            rinse_idx    <= 3'd0;
            water_level  <= 8'd0;
            cnt          <= 16'd0;
            elapsed_time <= '0;
            total_time   <= '0;
            wl           <= '0;
            hr           <= 1'b0;
            hs           <= 1'b0;
            paused       <= 1'b0;
            running      <= 1'b0;
            done         <= 1'b0;
            fill_valve   <= 1'b0;
            drain_valve  <= 1'b0;
            motor        <= 1'b0;
        end else begin
            state        <= state_n;
            stage        <= stage_n;
            rinse_idx    <= ridx_n;
            water_level  <= water_n;
            cnt          <= cnt_n;
            elapsed_time <= el_n;
            total_time   <= tot_n;
            wl           <= wl_n;
            hr           <= hr_n;
            hs           <= hs_n;
            paused       <= pz_n;
            running      <= act_n;
            done         <= state_n == DONE;
            fill_valve   <= (state_n == FILL) && !pz_n;
            drain_valve  <= ((state_n == DRAIN) || (state_n == SPIN)) && !pz_n;
            motor        <= ((state_n == AGITATE) || (state_n == SPIN)) && !pz_n;
        end
    end
endmodule
